// File: rtl/board_pkg.sv
// Shared types for the 5x5 board game core.
// Cell encoding, FSM states and the board image.
package board_pkg;

   localparam int BOARD_N = 5;

   typedef enum logic [1:0] {
      CELL_EMPTY  = 2'b00,
      CELL_CURSOR = 2'b01,
      CELL_PLAYER = 2'b10,
      CELL_PC     = 2'b11
   } cell_t;

   typedef enum logic [1:0] {
      ST_PLAYER,
      ST_PC_WAIT,
      ST_SEED,
      ST_FULL
   } state_t;

   typedef logic [2:0] idx_t;

   typedef logic [0:BOARD_N-1][0:BOARD_N-1][1:0] board_t;

   function automatic board_t reset_board();
      board_t b;
      b = '0;
      b[0][0] = CELL_CURSOR;
      return b;
   endfunction

endpackage

// File: rtl/board_state_first_empty.sv
// Combinational search for the first empty cell.
// Row-major order: i first, then j.
module first_empty
   import board_pkg::*;
(
   input  board_t board,
   output logic   found,
   output idx_t   fi,
   output idx_t   fj
);

   // Scan backwards so the lowest row-major empty cell is the last hit
   always_comb begin
      found = 1'b0;
      fi    = '0;
      fj    = '0;
      for (int i = BOARD_N - 1; i >= 0; i--) begin
         for (int j = BOARD_N - 1; j >= 0; j--) begin
            if (board[i][j] == CELL_EMPTY) begin
               found = 1'b1;
               fi    = idx_t'(i);
               fj    = idx_t'(j);
            end
         end
      end
   end

endmodule

// File: rtl/board_state.sv
// Board state keeper: player cursor, turn timer,
// PC move handshake and cursor seeding.
module board_state
   import board_pkg::*;
#(
   parameter int unsigned TURN_CYCLES = 750_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       move_req,
   input  logic [4:0] row,
   input  logic [4:0] col,
   input  logic       confirm,
   input  logic       pc_valid,
   input  logic [2:0] pc_i,
   input  logic [2:0] pc_j,
   output logic       pc_ack,
   output board_t     matrix_pc,
   output logic       player_turn,
   output logic       turn_timeout,
   output logic       board_full
);

   localparam int TW = $clog2(TURN_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TURN_CYCLES - 1);

   state_t          state_q, state_d;
   board_t          board_q, board_d;
   idx_t            cur_i_q, cur_i_d;
   idx_t            cur_j_q, cur_j_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            pc_ack_q, pc_ack_d;
   logic            tmo_q, tmo_d;
   logic            full_q, full_d;
   logic            turn_q, turn_d;

   board_t          fe_board;
   logic            fe_found;
   idx_t            fe_i, fe_j;
   logic            expire;
   idx_t            mv_i, mv_j;

   // Board as it looks once the cursor cell holds a player piece
   always_comb begin
      fe_board = board_q;
      fe_board[cur_i_q][cur_j_q] = CELL_PLAYER;
   end

   first_empty u_first_empty (
      .board (fe_board),
      .found (fe_found),
      .fi    (fe_i),
      .fj    (fe_j)
   );

   // Turn FSM, board writes and timer
   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      cur_i_d  = cur_i_q;
      cur_j_d  = cur_j_q;
      timer_d  = timer_q;
      pc_ack_d = 1'b0;
      tmo_d    = 1'b0;
      expire   = 1'b0;
      mv_i     = col[2:0];
      mv_j     = row[2:0];
      unique case (state_q)
         ST_PLAYER: begin
            expire = (timer_q == T_LAST);
            if (confirm || expire) begin
               board_d[cur_i_q][cur_j_q] = CELL_PLAYER;
               timer_d = '0;
               tmo_d   = expire;
               state_d = fe_found ? ST_PC_WAIT : ST_FULL;
            end else if (move_req && (col <= 5'd4) && (row <= 5'd4)
                         && (board_q[mv_i][mv_j] == CELL_EMPTY)) begin
               board_d[cur_i_q][cur_j_q] = CELL_EMPTY;
               board_d[mv_i][mv_j]       = CELL_CURSOR;
               cur_i_d = mv_i;
               cur_j_d = mv_j;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_PC_WAIT: begin
            timer_d = '0;
            if (pc_valid && (pc_i <= 3'd4) && (pc_j <= 3'd4)) begin
               if (board_q[pc_i][pc_j] == CELL_EMPTY) begin
                  board_d[pc_i][pc_j] = CELL_PC;
                  pc_ack_d = 1'b1;
                  state_d  = ST_SEED;
               end
            end
         end
         ST_SEED: begin
            timer_d = '0;
            if (fe_found) begin
               board_d[fe_i][fe_j] = CELL_CURSOR;
               cur_i_d = fe_i;
               cur_j_d = fe_j;
               state_d = ST_PLAYER;
            end else begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            timer_d = '0;
         end
         default: begin
            state_d = ST_FULL;
         end
      endcase
      turn_d = (state_d == ST_PLAYER);
      full_d = (state_d == ST_FULL);
   end

   // State, board and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_PLAYER;
         board_q  <= reset_board();
         cur_i_q  <= '0;
         cur_j_q  <= '0;
         timer_q  <= '0;
         pc_ack_q <= 1'b0;
         tmo_q    <= 1'b0;
         full_q   <= 1'b0;
         turn_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         cur_i_q  <= cur_i_d;
         cur_j_q  <= cur_j_d;
         timer_q  <= timer_d;
         pc_ack_q <= pc_ack_d;
         tmo_q    <= tmo_d;
         full_q   <= full_d;
         turn_q   <= turn_d;
      end
   end

   assign matrix_pc    = board_q;
   assign pc_ack       = pc_ack_q;
   assign turn_timeout = tmo_q;
   assign board_full   = full_q;
   assign player_turn  = turn_q;

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 750_000_000 (15 s at 50 MHz): player-turn timeout in clk cycles.
REQ-002 SHALL have ports, one clock, asynchronous active-low reset:
  clk  in  1  system clock
  rst_n  in  1  asynchronous active-low reset
  move_req  in  1  one-cycle pulse, player pressed a move button (move_h or move_v)
  row  in  5  target column index j from the cursor-move logic
  col  in  5  target row index i from the cursor-move logic
  confirm  in  1  one-cycle pulse, player places piece at cursor
  pc_valid  in  1  PC move valid, held until accepted
  pc_i  in  3  PC target row index
  pc_j  in  3  PC target column index
  pc_ack  out  1  one-cycle pulse, PC move accepted
  matrix_pc  out  2x[0:4][0:4]  board, registered, indexed [i][j]
  player_turn  out  1  high in ST_PLAYER
  turn_timeout  out  1  one-cycle pulse on timer expiry
  board_full  out  1  high in ST_FULL

Function
REQ-003 SHALL encode cells as: 00 empty, 01 cursor, 10 player piece, 11 PC piece; at most one 01 cell at any time.
REQ-004 SHALL implement FSM states ST_PLAYER, ST_PC_WAIT, ST_SEED, ST_FULL.
REQ-005 In ST_PLAYER, move_req without confirm SHALL, at the next edge, write 00 to the cursor cell and 01 to cell [col][row], only if col<=4, row<=4, target is 00; otherwise SHALL ignore the request.
REQ-006 In ST_PLAYER, confirm SHALL, at the next edge, write 10 to the cursor cell, clear the timer, and go to ST_PC_WAIT, or to ST_FULL if no 00 cell remains.
REQ-007 confirm and move_req in the same cycle: confirm SHALL win; move SHALL be dropped.
REQ-008 The timer SHALL count clk cycles in ST_PLAYER from 0 and reset to 0 on a legal move; on reaching TURN_CYCLES-1, it SHALL pulse turn_timeout for one cycle and act as confirm in that same cycle.
REQ-009 In ST_PC_WAIT with pc_valid, a move SHALL be accepted if pc_i<=4, pc_j<=4, and the target is 00: write 11, pulse pc_ack, go to ST_SEED; otherwise no write, no pc_ack, remain waiting.
REQ-010 ST_SEED SHALL write 01 to the first 00 cell in row-major order (i then j) and go to ST_PLAYER, or go to ST_FULL if none exist; duration exactly one cycle.
REQ-011 ST_FULL SHALL be terminal until reset, with all inputs ignored.
REQ-012 move_req and confirm SHALL be ignored outside ST_PLAYER; pc_valid SHALL be ignored outside ST_PC_WAIT.
REQ-013 All outputs SHALL be registered; each board update SHALL be visible one cycle after the causing input edge.

Reset
REQ-014 On rst_n low, immediately: all cells 00 except [0][0]=01, cursor (0,0), state ST_PLAYER, timer 0, pc_ack 0, turn_timeout 0, board_full 0, player_turn 1.
REQ-015 Reset asserted mid-turn or mid-PC-handshake SHALL abandon the operation with no partial write retained.

Structure
REQ-016 Shared package board_pkg SHALL hold: BOARD_N=5, cell_t encoding (CELL_EMPTY/CURSOR/PLAYER/PC), state enum, board_t array type.
REQ-017 A combinational sub-module first_empty SHALL return found flag and (i,j) of the first 00 cell in row-major order; it SHALL be used by REQ-006 and REQ-010.

Verification (TURN_CYCLES=8)
REQ-018 Reset, then move_req with row=1, col=0 -> next cycle [0][0]=00, [0][1]=01.
REQ-019 Cursor at (0,0), confirm -> [0][0]=10, player_turn=0; pc_valid (0,0) -> no ack; pc_valid (2,3) -> pc_ack, [2][3]=11; one cycle later cursor at [0][1].
REQ-020 move_req and confirm in the same cycle -> cursor cell becomes 10, no cursor move.
REQ-021 Idle 8 cycles in ST_PLAYER -> turn_timeout pulse on the 8th cycle, cursor cell 10, state ST_PC_WAIT.
REQ-022 Fill 24 cells, confirm on the last empty cell -> board_full=1, later move_req and pc_valid produce no change.
REQ-023 Assert rst_n mid ST_PC_WAIT with pc_valid high -> board returns to reset image, no pc_ack.
